execute_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage, fed directly by the decode-to-execute

---
 rtl/execute_muldiv_unit_if.sv | 29 ++
 rtl/execute_muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_unit_if.sv
// execute_muldiv_unit_if: groups the ID/EX-facing request and EX/MEM-facing result signals of the mul/div unit.
// Latency: none (wires only).
// Backpressure: busy travels back to the pipeline; result side has no ready (strobe only).
// Ports: master = pipeline side (drives start/flush/func3/operandA/operandB/rdIn),
//        slave  = unit side (drives busy/resultValid/result/rdOut).
interface execute_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic [4:0]      rdIn;
  logic            busy;
  logic            resultValid;
  logic [XLEN-1:0] result;
  logic [4:0]      rdOut;

  modport master (
    output start, flush, func3, operandA, operandB, rdIn,
    input  busy, resultValid, result, rdOut
  );

  modport slave (
    input  start, flush, func3, operandA, operandB, rdIn,
    output busy, resultValid, result, rdOut
  );
endinterface

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV32M multiply/divide, one bit per clock, on operand magnitudes.
// Latency: resultValid XLEN+1 cycles after the accept edge; div-by-zero / signed overflow 1 cycle.
// Backpressure: busy stalls PC/IF/ID/ID-EX while accepting or iterating; the result strobe has no ready.
// Ports: clock, reset (async active-low), bus (slave modport of execute_muldiv_unit_if):
//   in  start, flush, func3, operandA, operandB, rdIn; out busy, resultValid, result, rdOut.
module execute_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  execute_muldiv_unit_if.slave bus
);
  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   counter;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addend_q;   // |A| for multiply, |B| (divisor) for divide
  logic [XLEN-1:0] hi_q;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q;       // multiplier bits / dividend bits turning into quotient
  logic            neg_main_q; // product or quotient must be negated
  logic            neg_rem_q;  // remainder takes the dividend's sign
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            accept;

  // ---------------- operand decode (IDLE side) ----------------
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.func3)
      F_MUL, F_MULH, F_DIV, F_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F_MULHSU: a_signed = 1'b1;
      default:  ;
    endcase
    sign_a   = a_signed & bus.operandA[XLEN-1];
    sign_b   = b_signed & bus.operandB[XLEN-1];
    abs_a    = sign_a ? -bus.operandA : bus.operandA;
    abs_b    = sign_b ? -bus.operandB : bus.operandB;
    is_div   = bus.func3[2];
    div_zero = is_div & (bus.operandB == '0);
    // Only DIV/REM (func3[0]==0) can overflow: MIN / -1 does not fit.
    div_ovf  = is_div & ~bus.func3[0] & (bus.operandA == MIN_NEG) & (bus.operandB == '1);
    special  = div_zero | div_ovf;
    // func3[1] selects remainder within the divide group.
    if (div_zero) special_val = bus.func3[1] ? bus.operandA : '1;
    else          special_val = bus.func3[1] ? '0 : MIN_NEG;
  end

  assign accept = (state == IDLE) & bus.start & ~bus.flush;

  // ---------------- one iteration ----------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   mul_res, quo, rem, calc_res;

  always_comb begin
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole {hi,lo} pair right.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    // Restoring divide: bring in the next dividend bit, try to subtract.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, addend_q};
    div_ok    = ~div_diff[XLEN];
    if (op_q[2]) begin
      hi_nxt = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], div_ok};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    // Sign correction of the final iteration's outcome, loaded in the same edge.
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_main_q ? -prod : prod;
    mul_res  = (op_q == F_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    quo      = neg_main_q ? -lo_nxt : lo_nxt;
    rem      = neg_rem_q ? -hi_nxt : hi_nxt;
    calc_res = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.busy        = 1'b0;
    bus.resultValid = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = accept;
        if (accept) state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (counter == LAST) state_nxt = DONE;
      end
      DONE: begin
        // start is still the same instruction here, so it is ignored.
        bus.resultValid = ~bus.flush;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter    <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      addend_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else if (accept) begin
      op_q       <= bus.func3;
      rd_q       <= bus.rdIn;
      counter    <= '0;
      hi_q       <= '0;
      neg_main_q <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
      if (is_div) begin
        addend_q <= abs_b;
        lo_q     <= abs_a;
      end else begin
        addend_q <= abs_a;
        lo_q     <= abs_b;
      end
      if (special) begin
        result_q <= special_val;
        rd_out_q <= bus.rdIn;
      end
    end else if (state == CALC && !bus.flush) begin
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      counter <= counter + CW'(1);
      if (counter == LAST) begin
        result_q <= calc_res;
        rd_out_q <= rd_q;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.rdOut  = rd_out_q;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: directed + random checks of execute_muldiv_unit against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_execute_muldiv_unit;
  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  execute_muldiv_unit_if #(.XLEN(32)) bus ();

  execute_muldiv_unit #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // RV32M semantics via 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Entered in an IDLE cycle (posedge+2); leaves in the strobe cycle with start still held.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp_r;
    int exp_lat, lat, busy_cnt;
    logic seen;
    exp_r   = ref_model(f3, a, b);
    exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    bus.start = 1'b1; bus.flush = 1'b0; bus.func3 = f3;
    bus.operandA = a; bus.operandB = b; bus.rdIn = rd;
    #1;
    check_bit("accept_busy", bus.busy, 1'b1);
    check_bit("accept_no_strobe", bus.resultValid, 1'b0);
    busy_cnt = 1; lat = 0; seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #2;
      if (bus.resultValid) begin seen = 1'b1; lat = n; break; end
      if (bus.busy) busy_cnt++;
    end
    check_bit("strobe_seen", seen, 1'b1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    check("result", bus.result, exp_r);
    check("rdOut", {27'b0, bus.rdOut}, {27'b0, rd});
    check_bit("done_busy", bus.busy, 1'b0);
    last_res = exp_r;
    last_rd  = rd;
  endtask

  // Drop start after a strobe; the next cycle must not strobe again.
  task automatic idle_step();
    bus.start = 1'b0;
    @(posedge clock); #2;
    check_bit("single_strobe", bus.resultValid, 1'b0);
  endtask

  initial begin
    int strobes;
    logic [2:0] f3;
    n_assert = 0; n_fail = 0; last_res = '0; last_rd = '0;
    reset = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = '0;
    bus.operandA = '0; bus.operandB = '0; bus.rdIn = '0;
    repeat (2) @(posedge clock); #2;
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_valid", bus.resultValid, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_rdOut", {27'b0, bus.rdOut}, 32'h0);
    reset = 1'b1;
    @(posedge clock); #2;

    // Directed arithmetic
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);        idle_step();
    check("mul_7_m3", last_res, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2); idle_step();
    check("mulhu_ff", last_res, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3); idle_step();
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4);         idle_step();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);         idle_step();
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);         idle_step();
    run_op(3'd5, 32'd100, 32'd7, 5'd7);               idle_step();
    run_op(3'd7, 32'd100, 32'd7, 5'd8);               idle_step();
    // Special cases
    run_op(3'd5, 32'd5, 32'd0, 5'd9);                 idle_step();
    run_op(3'd6, 32'd5, 32'd0, 5'd10);                idle_step();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11); idle_step();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12); idle_step();

    // Flush at CALC cycle 10, then a new op the following cycle
    bus.start = 1'b1; bus.func3 = 3'd5; bus.operandA = 32'd1000; bus.operandB = 32'd3; bus.rdIn = 5'd13;
    @(posedge clock); #2;
    repeat (9) begin @(posedge clock); #2; end
    bus.flush = 1'b1; bus.start = 1'b0;
    @(posedge clock); #2;
    bus.flush = 1'b0;
    #1;
    check_bit("flush_busy", bus.busy, 1'b0);
    check_bit("flush_no_strobe", bus.resultValid, 1'b0);
    check("flush_result_kept", bus.result, last_res);
    check("flush_rd_kept", {27'b0, bus.rdOut}, {27'b0, last_rd});
    #1;
    run_op(3'd0, 32'd12345, 32'd678, 5'd14);          idle_step();

    // Flush together with start in IDLE: nothing accepted (a special op would strobe next cycle)
    bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'd5; bus.operandA = 32'd9; bus.operandB = 32'd0; bus.rdIn = 5'd15;
    #1;
    check_bit("flush_start_busy", bus.busy, 1'b0);
    @(posedge clock); #2;
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check_bit("flush_start_no_strobe", bus.resultValid, 1'b0);
    @(posedge clock); #2;

    // Flush in the DONE cycle suppresses the strobe
    bus.start = 1'b1; bus.func3 = 3'd0; bus.operandA = 32'd3; bus.operandB = 32'd5; bus.rdIn = 5'd16;
    repeat (33) begin @(posedge clock); #2; end
    bus.flush = 1'b1;
    #1;
    check_bit("done_flush_no_strobe", bus.resultValid, 1'b0);
    @(posedge clock); #2;
    bus.flush = 1'b0; bus.start = 1'b0;
    #1;
    check_bit("after_done_flush", bus.resultValid, 1'b0);
    @(posedge clock); #2;

    // Reset mid-CALC
    bus.start = 1'b1; bus.func3 = 3'd4; bus.operandA = 32'd77; bus.operandB = 32'd5; bus.rdIn = 5'd17;
    repeat (6) begin @(posedge clock); #2; end
    bus.start = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_bit("midrst_busy", bus.busy, 1'b0);
    check_bit("midrst_valid", bus.resultValid, 1'b0);
    check("midrst_result", bus.result, 32'h0);
    check("midrst_rdOut", {27'b0, bus.rdOut}, 32'h0);
    @(posedge clock); #2;
    reset = 1'b1;
    strobes = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #2;
      if (bus.resultValid) strobes++;
    end
    check("midrst_no_strobe", 32'(strobes), 32'd0);

    // Back-to-back: start held through DONE, next op presented in the DONE cycle
    run_op(3'd7, 32'd1234567, 32'd1000, 5'd18);
    bus.func3 = 3'd2; bus.operandA = 32'h8765_4321; bus.operandB = 32'h1234_5678; bus.rdIn = 5'd19;
    #1;
    check_bit("b2b_done_busy", bus.busy, 1'b0);
    @(posedge clock); #2;
    run_op(3'd2, 32'h8765_4321, 32'h1234_5678, 5'd19);
    bus.func3 = 3'd4; bus.operandA = 32'd5; bus.operandB = 32'd0; bus.rdIn = 5'd20;
    @(posedge clock); #2;
    run_op(3'd4, 32'd5, 32'd0, 5'd20);                idle_step();

    // Random operations
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      run_op(f3, pick(), pick(), 5'($urandom_range(0, 31)));
      idle_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
